// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants used by the execute-stage units
package cpu_pkg;

   // Sequential multiplier control states
   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

   // Default operand width of the multi-cycle MUL unit
   localparam int MUL_WIDTH = 8;

endpackage

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - conditional two's-complement negation for multiplier sign handling
module mul_sign_fix #(
   parameter int W = 8
) (
   input  logic [W-1:0] din,
   input  logic         neg,
   output logic [W-1:0] dout
);

   // Negating the most negative value wraps to itself, which read as unsigned is
   // exactly its magnitude, so operand magnitudes never need an extra bit.
   always_comb begin
      dout = neg ? (~din + W'(1)) : din;
   end

endmodule

// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - multi-cycle shift-add multiplier with valid/ready handshakes
module multiplier_seq
   import cpu_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   product_lo,
   output logic               ovf
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   mul_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic               neg_flag;
   logic               sgn_mode;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] acc_next;
   logic [2*WIDTH-1:0] p_fix;
   logic [WIDTH-1:0]   p_hi;
   logic               ovf_next;

   mul_sign_fix #(.W(WIDTH)) u_fix_a (
      .din  (a),
      .neg  (is_signed & a[WIDTH-1]),
      .dout (a_mag)
   );

   mul_sign_fix #(.W(WIDTH)) u_fix_b (
      .din  (b),
      .neg  (is_signed & b[WIDTH-1]),
      .dout (b_mag)
   );

   mul_sign_fix #(.W(2*WIDTH)) u_fix_p (
      .din  (acc),
      .neg  (neg_flag),
      .dout (p_fix)
   );

   // One shift-add step: the upper half gains the multiplicand when the multiplier
   // LSB is set, the carry is kept, and everything shifts right by one.
   always_comb begin
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      acc_next = {sum, acc[WIDTH-1:1]};
   end

   // Overflow of the low half, judged on the sign-corrected product about to be loaded
   always_comb begin
      p_hi     = p_fix[2*WIDTH-1:WIDTH];
      ovf_next = sgn_mode ? (p_hi != {WIDTH{p_fix[WIDTH-1]}}) : (|p_hi);
   end

   assign product_lo = product[WIDTH-1:0];

   // Control FSM with registered handshake outputs; the DONE state spends one
   // edge loading the result before presenting out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= MUL_IDLE;
         cnt       <= '0;
         mcand     <= '0;
         acc       <= '0;
         neg_flag  <= 1'b0;
         sgn_mode  <= 1'b0;
         product   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         case (state)
            MUL_IDLE: begin
               if (in_ready && in_valid) begin
                  mcand    <= a_mag;
                  acc      <= {{WIDTH{1'b0}}, b_mag};
                  neg_flag <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  sgn_mode <= is_signed;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= MUL_BUSY;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            MUL_BUSY: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt   <= '0;
                  state <= MUL_DONE;
               end
            end
            MUL_DONE: begin
               if (!out_valid) begin
                  product   <= p_fix;
                  ovf       <= ovf_next;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= MUL_IDLE;
               end
            end
            default: begin
               state     <= MUL_IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - self-checking bench for multiplier_seq at WIDTH 8 and 16
module tb_multiplier_seq;

   logic clk;
   logic rst;

   logic        in_valid8, in_ready8, s8, out_valid8, out_ready8, ovf8;
   logic [7:0]  a8, b8, product_lo8;
   logic [15:0] product8;

   logic        in_valid16, in_ready16, s16, out_valid16, out_ready16, ovf16;
   logic [15:0] a16, b16, product_lo16;
   logic [31:0] product16;

   int checks = 0;
   int errors = 0;

   multiplier_seq #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid8),
      .in_ready   (in_ready8),
      .a          (a8),
      .b          (b8),
      .is_signed  (s8),
      .out_valid  (out_valid8),
      .out_ready  (out_ready8),
      .product    (product8),
      .product_lo (product_lo8),
      .ovf        (ovf8)
   );

   multiplier_seq #(.WIDTH(16)) dut16 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid16),
      .in_ready   (in_ready16),
      .a          (a16),
      .b          (b16),
      .is_signed  (s16),
      .out_valid  (out_valid16),
      .out_ready  (out_ready16),
      .product    (product16),
      .product_lo (product_lo16),
      .ovf        (ovf16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Golden value of a as an integer of width w under the given mode
   function automatic longint op_val(input int w, input logic [15:0] v, input bit sgn);
      longint r;
      r = longint'(v);
      if (sgn && v[w-1]) r = r - (longint'(1) << w);
      return r;
   endfunction

   function automatic logic [31:0] ref_prod(input int w, input logic [15:0] x, input logic [15:0] y, input bit sgn);
      longint p;
      longint mask;
      p    = op_val(w, x, sgn) * op_val(w, y, sgn);
      mask = (longint'(1) << (2 * w)) - 1;
      return 32'(p & mask);
   endfunction

   function automatic bit ref_ovf(input int w, input logic [15:0] x, input logic [15:0] y, input bit sgn);
      longint p;
      p = op_val(w, x, sgn) * op_val(w, y, sgn);
      if (sgn) return (p < -(longint'(1) << (w - 1))) || (p >= (longint'(1) << (w - 1)));
      return p >= (longint'(1) << w);
   endfunction

   task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input bit is, input int stall,
                         output logic [15:0] p, output logic o, output int lat, output bit tmo);
      int w;
      tmo = 0;
      w   = 0;
      while (!in_ready8 && w < 50) begin tick(); w++; end
      if (!in_ready8) tmo = 1;
      a8 = ia; b8 = ib; s8 = is; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      lat = 0;
      while (!out_valid8 && lat < 100) begin tick(); lat++; end
      if (!out_valid8) tmo = 1;
      p = product8;
      o = ovf8;
      repeat (stall) tick();
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
   endtask

   task automatic do_op16(input logic [15:0] ia, input logic [15:0] ib, input bit is, input int stall,
                          output logic [31:0] p, output logic o, output int lat, output bit tmo);
      int w;
      tmo = 0;
      w   = 0;
      while (!in_ready16 && w < 50) begin tick(); w++; end
      if (!in_ready16) tmo = 1;
      a16 = ia; b16 = ib; s16 = is; in_valid16 = 1'b1;
      tick();
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 100) begin tick(); lat++; end
      if (!out_valid16) tmo = 1;
      p = product16;
      o = ovf16;
      repeat (stall) tick();
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (out_valid8 !== 1'b0 || product8 !== 16'h0 || ovf8 !== 1'b0 || in_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got ov=%b p=%h ovf=%b rdy=%b exp ov=0 p=0000 ovf=0 rdy=0",
                  out_valid8, product8, ovf8, in_ready8);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready8 !== 1'b1 || in_ready16 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %b/%b exp 1/1", in_ready8, in_ready16);
      end
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      bit          s;
      logic [15:0] p;
      bit          o;
   } dcase_t;

   task automatic test_directed();
      dcase_t cs[7];
      logic [15:0] p;
      logic o;
      int lat;
      bit tmo;
      cs[0] = '{8'd13, 8'd11, 1'b0, 16'h008F, 1'b0};
      cs[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b1};
      cs[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0};
      cs[3] = '{8'h80, 8'h80, 1'b1, 16'h4000, 1'b1};
      cs[4] = '{8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0};
      cs[5] = '{8'hFD, 8'h07, 1'b1, 16'hFFEB, 1'b0};
      cs[6] = '{8'h00, 8'hFF, 1'b0, 16'h0000, 1'b0};
      for (int i = 0; i < 7; i++) begin
         do_op8(cs[i].a, cs[i].b, cs[i].s, 0, p, o, lat, tmo);
         checks++;
         if (tmo || p !== cs[i].p || p[7:0] !== cs[i].p[7:0] || o !== cs[i].o || lat != 9) begin
            errors++;
            $display("FAIL directed_%0d got p=%h ovf=%b lat=%0d tmo=%b exp p=%h ovf=%b lat=9",
                     i, p, o, lat, tmo, cs[i].p, cs[i].o);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] held;
      int w;
      w = 0;
      while (!in_ready8 && w < 50) begin tick(); w++; end
      a8 = 8'd20; b8 = 8'd3; s8 = 1'b0; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      w = 0;
      while (!out_valid8 && w < 100) begin tick(); w++; end
      held = product8;
      checks++;
      if (held !== 16'd60) begin
         errors++;
         $display("FAIL bp_first got %h exp %h", held, 16'd60);
      end
      a8 = 8'd5; b8 = 8'd9; in_valid8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid8 !== 1'b1 || product8 !== 16'd60 || in_ready8 !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_%0d got ov=%b p=%h rdy=%b exp ov=1 p=003c rdy=0",
                     i, out_valid8, product8, in_ready8);
         end
      end
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      checks++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got ov=%b rdy=%b exp ov=0 rdy=1", out_valid8, in_ready8);
      end
      tick();
      in_valid8 = 1'b0;
      checks++;
      if (in_ready8 !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept got rdy=%b exp 0", in_ready8);
      end
      w = 0;
      while (!out_valid8 && w < 100) begin tick(); w++; end
      checks++;
      if (product8 !== 16'd45 || w != 9) begin
         errors++;
         $display("FAIL bp_pending got p=%h lat=%0d exp p=002d lat=9", product8, w);
      end
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [15:0] p;
      logic o;
      int lat;
      bit tmo;
      int w;
      w = 0;
      while (!in_ready8 && w < 50) begin tick(); w++; end
      a8 = 8'd200; b8 = 8'd200; s8 = 1'b0; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      checks++;
      if (out_valid8 !== 1'b0 || product8 !== 16'h0) begin
         errors++;
         $display("FAIL midreset_state got ov=%b p=%h exp ov=0 p=0000", out_valid8, product8);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL midreset_ready got rdy=%b ov=%b exp rdy=1 ov=0", in_ready8, out_valid8);
      end
      do_op8(8'd6, 8'd7, 1'b0, 0, p, o, lat, tmo);
      checks++;
      if (tmo || p !== 16'h002A || o !== 1'b0 || lat != 9) begin
         errors++;
         $display("FAIL midreset_next got p=%h ovf=%b lat=%0d exp p=002a ovf=0 lat=9", p, o, lat);
      end
   endtask

   task automatic test_random8();
      logic [7:0] ra, rb;
      bit rs;
      logic [15:0] p, ep;
      logic o;
      bit eo, tmo;
      int lat;
      for (int i = 0; i < 120; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom);
         ep = 16'(ref_prod(8, {8'h0, ra}, {8'h0, rb}, rs));
         eo = ref_ovf(8, {8'h0, ra}, {8'h0, rb}, rs);
         do_op8(ra, rb, rs, int'($urandom_range(0, 3)), p, o, lat, tmo);
         checks++;
         if (tmo || p !== ep || o !== eo || lat != 9) begin
            errors++;
            $display("FAIL rand8_%0d a=%h b=%h s=%b got p=%h ovf=%b lat=%0d exp p=%h ovf=%b lat=9",
                     i, ra, rb, rs, p, o, lat, ep, eo);
         end
      end
   endtask

   task automatic test_random16();
      logic [15:0] ra, rb;
      bit rs;
      logic [31:0] p, ep;
      logic o;
      bit eo, tmo;
      int lat;
      for (int i = 0; i < 60; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i == 0) begin ra = 16'h8000; rb = 16'h8000; end
         rs = 1'($urandom);
         ep = ref_prod(16, ra, rb, rs);
         eo = ref_ovf(16, ra, rb, rs);
         do_op16(ra, rb, rs, int'($urandom_range(0, 3)), p, o, lat, tmo);
         checks++;
         if (tmo || p !== ep || o !== eo || lat != 17) begin
            errors++;
            $display("FAIL rand16_%0d a=%h b=%h s=%b got p=%h ovf=%b lat=%0d exp p=%h ovf=%b lat=17",
                     i, ra, rb, rs, p, o, lat, ep, eo);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; out_ready8 = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; out_ready16 = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random8();
      test_random16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
